dmem_rw: RTL and testbench

- Read/write data memory for the core's load/store unit.
- Complements the read-only instruction memory: it accepts stores as well as loads.
- Word-organised little-endian array with byte-lane writes, RISC-V sizes (byte/half/word) and sign/zero extension on loads.
- Single request/response handshake with fixed latency; misaligned accesses are trapped, or split when the optional feature is compiled in.

---
 rtl/dmem_rw.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_rw.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rw.sv
// rtl/dmem_rw.sv - load/store data memory with byte lanes, RISC-V sizes and sign/zero extension
//
// Purpose: word-organised little-endian read/write array for the load/store unit.
//   Aligned accesses respond one cycle after acceptance. Accesses that span two
//   words are either rejected with err, or (with DMEM_MISALIGN_EN defined) split
//   over an extra SPLIT cycle and answered two cycles after acceptance.
// Optional feature macro: DMEM_MISALIGN_EN (undefined: spanning accesses return err).
// Ports:
//   clk, reset      clock; synchronous active-high reset (clears the whole array)
//   req_valid/ready request handshake, accepted when both are high
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    loads: 1 zero-extend, 0 sign-extend
//   address, wdata  byte address; store data taken from the low-order bytes
//   resp_valid      one-cycle response pulse
//   rdata, err      load result (0 for stores/errors); error flag

module dmem_rw #(
  parameter int XLEN       = 32,
  parameter int TAM        = 32,
  parameter int ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDRESSLEN-1:0] address,
  input  logic [XLEN-1:0]       wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       rdata,
  output logic                  err
);

  localparam int IDXW = $clog2(TAM);

`ifdef DMEM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state, state_n;

  logic [XLEN-1:0] mem [TAM];

  // Request captured at acceptance of a spanning access, replayed in SPLIT.
  logic [IDXW+1:0] sp_addr;
  logic [1:0]      sp_size;
  logic            sp_we;
  logic            sp_uns;
  logic [XLEN-1:0] sp_wdata;
  logic [XLEN-1:0] sp_part;

  // Address bits above the array index wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[ADDRESSLEN-1:IDXW+2];

  logic in_split;
  logic accept;
  assign in_split = (state == SPLIT);
  assign accept   = req_valid && req_ready;

  // One access engine serves both the first word (IDLE) and the second word (SPLIT).
  logic [IDXW+1:0] acc_addr;
  logic [1:0]      acc_size;
  logic            acc_we;
  logic            acc_uns;
  logic [XLEN-1:0] acc_wdata;
  logic [1:0]      acc_off;
  logic [IDXW-1:0] acc_word;
  logic [2:0]      acc_n;
  logic            illegal;
  logic            mis;
  logic            req_err;

  assign acc_addr  = in_split ? sp_addr  : address[IDXW+1:0];
  assign acc_size  = in_split ? sp_size  : req_size;
  assign acc_we    = in_split ? sp_we    : req_we;
  assign acc_uns   = in_split ? sp_uns   : req_unsigned;
  assign acc_wdata = in_split ? sp_wdata : wdata;
  assign acc_off   = acc_addr[1:0];
  // Second half of a split targets the next word, wrapping TAM-1 -> 0.
  assign acc_word  = acc_addr[IDXW+1:2] + IDXW'(in_split);

  always_comb begin
    acc_n = 3'd4;
    case (acc_size)
      2'b00:   acc_n = 3'd1;
      2'b01:   acc_n = 3'd2;
      default: acc_n = 3'd4;
    endcase
  end

  assign illegal = (acc_size == 2'b11);
  // A half at offset 01 stays inside the word; only offset 11 spans.
  assign mis     = ((acc_size == 2'b01) && (acc_off == 2'b11)) ||
                   ((acc_size == 2'b10) && (acc_off != 2'b00));
  assign req_err = illegal || (mis && !MIS_EN);

  // Lane mapping: lane l carries data byte k = l + 4*in_split - offset.
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] gather;
  logic [3:0]      lane_en;
  logic [1:0]      lane_k [4];
  int              k;

  assign rd_word = mem[acc_word];

  always_comb begin
    gather  = in_split ? sp_part : '0;
    lane_en = '0;
    k       = 0;
    for (int l = 0; l < 4; l++) begin
      lane_k[l] = 2'd0;
      k = l + (in_split ? 4 : 0) - int'(acc_off);
      if (k >= 0 && k < int'(acc_n)) begin
        lane_en[l] = 1'b1;
        lane_k[l]  = 2'(k);
        gather[8*lane_k[l] +: 8] = rd_word[8*l +: 8];
      end
    end
  end

  logic [XLEN-1:0] load_val;
  always_comb begin
    load_val = gather;
    case (acc_size)
      2'b00:   load_val = acc_uns ? {{(XLEN-8){1'b0}}, gather[7:0]}
                                  : {{(XLEN-8){gather[7]}}, gather[7:0]};
      2'b01:   load_val = acc_uns ? {{(XLEN-16){1'b0}}, gather[15:0]}
                                  : {{(XLEN-16){gather[15]}}, gather[15:0]};
      default: load_val = gather;
    endcase
  end

  logic do_write;
  assign do_write = acc_we && (in_split || (accept && !req_err));

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset && mis && MIS_EN) state_n = SPLIT;
      end
      SPLIT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: array writes, split capture and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAM; i++) mem[i] <= '0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      sp_addr    <= '0;
      sp_size    <= 2'b00;
      sp_we      <= 1'b0;
      sp_uns     <= 1'b0;
      sp_wdata   <= '0;
      sp_part    <= '0;
    end else begin
      resp_valid <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      if (do_write) begin
        for (int l = 0; l < 4; l++)
          if (lane_en[l]) mem[acc_word][8*l +: 8] <= acc_wdata[8*lane_k[l] +: 8];
      end
      if (in_split) begin
        resp_valid <= 1'b1;
        rdata      <= sp_we ? '0 : load_val;
      end else if (accept) begin
        if (req_err) begin
          resp_valid <= 1'b1;
          err        <= 1'b1;
        end else if (mis) begin
          sp_addr  <= address[IDXW+1:0];
          sp_size  <= req_size;
          sp_we    <= req_we;
          sp_uns   <= req_unsigned;
          sp_wdata <= wdata;
          sp_part  <= gather;
        end else begin
          resp_valid <= 1'b1;
          rdata      <= req_we ? '0 : load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_rw.sv
// tb/tb_dmem_rw.sv - self-checking bench for dmem_rw against a byte-stream memory model
module tb_dmem_rw;
  localparam int TAM = 32;
  localparam int NB  = TAM * 4;
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  int tests = 0;
  int fails = 0;
  logic [7:0] mb [NB];

  dmem_rw #(.XLEN(32), .TAM(TAM), .ADDRESSLEN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .address(address), .wdata(wdata), .resp_valid(resp_valid),
    .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
  endtask

  // Memory as a flat little-endian byte stream modulo NB bytes.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output logic [31:0] r, output int lat);
    int n, off, base, b;
    logic m;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    m   = (sz == 2'd1 && off == 3) || (sz == 2'd2 && off != 0);
    e = 1'b0; r = '0; lat = 1;
    if (sz == 2'd3 || (m && !MIS)) begin
      e = 1'b1;
      return;
    end
    lat  = m ? 2 : 1;
    base = int'(a % 32'(NB));
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = (base + i) % NB;
      if (we) mb[b] = wd[8*i +: 8];
      else    v[8*i +: 8] = mb[b];
    end
    if (!we) begin
      if (n == 1 && !uns && v[7])  v = v | 32'hFFFFFF00;
      if (n == 2 && !uns && v[15]) v = v | 32'hFFFF0000;
      r = v;
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; address = a; wdata = wd;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    #1 chk({tag, " ready_in_reset"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " rdata"}, rdata, 32'd0);
    reset = 1'b0;
    #1 chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    clear_model();
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic e;
    logic [31:0] r;
    int lat, w;
    model(we, sz, uns, a, wd, e, r, lat);
    @(negedge clk);
    drive(we, sz, uns, a, wd);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (lat == 2) begin
      chk({tag, " split_no_resp"}, 32'(resp_valid), 32'd0);
      chk({tag, " split_ready_low"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      chk({tag, " split_ready_back"}, 32'(req_ready), 32'd1);
    end
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " err"}, 32'(err), 32'(e));
    chk({tag, " rdata"}, rdata, r);
  endtask

  initial begin
    logic e0, e1, e2;
    logic [31:0] r0, r1, r2;
    int l0, l1, l2;
    logic rwe, runs;
    logic [1:0] rsz;

    clear_model();
    do_reset("rst0");

    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw0_after_reset");
    chk("lw0_literal", rdata, 32'h0);

    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, "sw8");
    issue(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, "lb_b");
    chk("lb_b_literal", rdata, 32'hFFFFFFDE);
    issue(1'b0, 2'd0, 1'b1, 32'hB, 32'h0, "lbu_b");
    chk("lbu_b_literal", rdata, 32'h000000DE);
    issue(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, "lh_8");
    chk("lh_8_literal", rdata, 32'hFFFFBEEF);

    // Back-to-back SW, SB, LW: one accept and one response per cycle.
    model(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344, e0, r0, l0);
    model(1'b1, 2'd0, 1'b0, 32'h5, 32'h000000AA, e1, r1, l1);
    model(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, e2, r2, l2);
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344); req_valid = 1'b1;
    chk("b2b ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b resp0", 32'(resp_valid), 32'd1);
    chk("b2b err0", 32'(err), 32'(e0));
    chk("b2b rdata0", rdata, r0);
    drive(1'b1, 2'd0, 1'b0, 32'h5, 32'h000000AA);
    chk("b2b ready1", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b resp1", 32'(resp_valid), 32'd1);
    chk("b2b rdata1", rdata, r1);
    drive(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    chk("b2b ready2", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b resp2", 32'(resp_valid), 32'd1);
    chk("b2b rdata2", rdata, r2);
    chk("b2b rdata2_literal", rdata, 32'h1122AA44);
    @(negedge clk);
    chk("b2b no_resp_idle", 32'(resp_valid), 32'd0);

    issue(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "lh_6");
    issue(1'b0, 2'd1, 1'b1, 32'h5, 32'h0, "lhu_5_offset01");
    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, "lw_2_mis");
    issue(1'b1, 2'd2, 1'b0, 32'h2, 32'h55667788, "sw_2_mis");
    issue(1'b1, 2'd1, 1'b0, 32'h7, 32'h00009999, "sh_7_mis");
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw_4_after_mis");
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "lw_8_after_mis");
    issue(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, "sz11_store");
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw_0_after_sz11");

`ifdef DMEM_MISALIGN_EN
    issue(1'b1, 2'd2, 1'b0, 32'h7E, 32'hCAFEF00D, "sw_7e_wrap");
    issue(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, "lw_7c");
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw_0_wrap");
    issue(1'b0, 2'd2, 1'b0, 32'h7E, 32'h0, "lw_7e_wrap");
    chk("lw_7e_literal", rdata, 32'hCAFEF00D);
    // Reset in the SPLIT cycle abandons the access.
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 32'h3E, 32'h12345678); req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_split ready_low", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_split no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_split no_resp_after", 32'(resp_valid), 32'd0);
    for (int i = 0; i < TAM; i++)
      issue(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, "rst_split_clear");
`endif

    for (int t = 0; t < 250; t++) begin
      rwe  = 1'($urandom_range(0, 1));
      runs = 1'($urandom_range(0, 1));
      rsz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(rwe, rsz, runs, 32'($urandom_range(0, 2 * NB - 1)), $urandom, "rand");
    end

    do_reset("rst1");
    for (int i = 0; i < TAM; i++)
      issue(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, "clear_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
